seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter CLK_DIV, default 50000: clk cycles per scan tick, legal range >=1.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 digits  input  4*NUM_DIGITS  packed digit values; digit i = bits [4i+3:4i]; digit 0 is rightmost.
REQ-006 dp  input  NUM_DIGITS  per-digit decimal point request, 1 = lit.
REQ-007 digit_en  input  NUM_DIGITS  per-digit enable, 0 = digit dark.
REQ-008 brightness  input  4  on-time in ticks per digit slot, 0 = dark, 15 = max.
REQ-009 hex_mode  input  1  1 = decode 0-F; 0 = BCD, values 10-15 blank.
REQ-010 lz_blank  input  1  1 = suppress leading zeros.
REQ-011 seg_n  output  7  segments, active-low; bit0 = a through bit6 = g.
REQ-012 dp_n  output  1  decimal point, active-low.
REQ-013 an_n  output  NUM_DIGITS  digit anode selects, active-low, at most one low.
REQ-014 frame_start  output  1  one-clk pulse when a new frame's inputs are captured.

Function
REQ-015 Prescaler counts 0..CLK_DIV-1 and raises internal tick on the clk where it equals CLK_DIV-1, then wraps to 0; CLK_DIV=1 gives a tick on every clk.
REQ-016 A 4-bit phase counter increments on each tick; on wrap from 15 to 0, digit index increments, wrapping from NUM_DIGITS-1 to 0.
REQ-017 A slot is 16 ticks; a frame is 16*NUM_DIGITS ticks = 16*NUM_DIGITS*CLK_DIV clks.
REQ-018 Shadow registers capture digits, dp, digit_en, brightness, hex_mode and lz_blank on the tick that moves (index,phase) to (0,0), and on the first clk after rst deasserts; frame_start pulses on that same clk.
REQ-019 Input changes between captures have no effect on outputs until the next capture.
REQ-020 Phase 0 of every slot is dead time: all an_n high, to prevent ghosting.
REQ-021 In phases 1..15, an_n[index] is low iff phase <= shadow brightness and the digit is visible; all other an_n bits are high.
REQ-022 Digit visible = digit_en[i] = 1 and not leading-zero-blanked.
REQ-023 With lz_blank = 1, digit i (i>=1) is blanked if it and every higher-index digit equal 0; digit 0 is never blanked. With lz_blank = 0, nothing is blanked.
REQ-024 seg_n decode, active-low gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-025 With hex_mode = 0, values 10-15 give seg_n = 1111111; the anode still follows REQ-021.
REQ-026 dp_n = ~dp[index] while an_n[index] is low, else 1.
REQ-027 seg_n is 1111111 whenever all an_n are high.
REQ-028 All outputs are registered and reflect (index,phase) with exactly one clk latency.
REQ-029 Digit scan order is 0,1,...,NUM_DIGITS-1,0; with NUM_DIGITS = 1, index stays 0.

Reset
REQ-030 While rst is high: prescaler, phase and index = 0; shadows = 0; seg_n = 1111111, dp_n = 1, an_n = all ones, frame_start = 0.
REQ-031 rst asserted mid-frame applies REQ-030 on the next clk edge; scanning restarts at digit 0, phase 0, with the REQ-018 capture.

Verification
REQ-032 rst high 3 clks, then low -> outputs at REQ-030 values during reset; frame_start = 1 on first clk after release, 0 on the next.
REQ-033 NUM_DIGITS=4, CLK_DIV=1, digits=16'h1234, digit_en=F, brightness=15, lz_blank=0, hex_mode=0 -> slot 0: 1 dead clk, then an_n=1110 and seg_n=0011001 for 15 clks; slots 1-3 show 3,2,1; frame_start every 64 clks.
REQ-034 brightness=4 -> an_n low for 4 of 16 clks per slot; brightness=0 -> an_n never low.
REQ-035 lz_blank=1, digits=16'h0070 -> digits 3 and 2 never selected, digits 1 and 0 show 7,0; digits=16'h0000 -> only digit 0 shows 0.
REQ-036 digits changed from 16'h1234 to 16'h5678 during slot 1 -> slots 1-3 still show 3,2,1; the new value appears after the next frame_start.
REQ-037 digit value A: hex_mode=1 -> seg_n=0001000; hex_mode=0 -> anode low, seg_n=1111111; dp=0001 -> dp_n=0 only during digit 0 on-time.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// Display-side bundle for the seven-segment scanner: captured inputs toward the
// controller, active-low drive signals and the frame marker back out.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [3:0]              brightness;
  logic                    hex_mode;
  logic                    lz_blank;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    frame_start;

  modport master (
    output digits, dp, digit_en, brightness, hex_mode, lz_blank,
    input  seg_n, dp_n, an_n, frame_start
  );

  modport slave (
    input  digits, dp, digit_en, brightness, hex_mode, lz_blank,
    output seg_n, dp_n, an_n, frame_start
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller: per-digit 16-tick slots with a dead
// phase, PWM brightness, leading-zero blanking and frame-aligned input capture.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000
) (
  input  logic            clk,
  input  logic            rst,
  seg7_scan_ctrl_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]        presc_q, presc_d;
  logic [3:0]              phase_q, phase_d;
  logic [IDX_W-1:0]        index_q, index_d;
  logic                    start_q, start_d;
  logic                    capture_s;

  logic [4*NUM_DIGITS-1:0] dig_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   en_q;
  logic [3:0]              bright_q;
  logic                    hex_q;
  logic                    lz_q;

  logic [6:0]              seg_q, seg_d;
  logic                    dpn_q, dpn_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fs_q, fs_d;

  logic [NUM_DIGITS-1:0]   vis_s;
  logic                    zero_run_s;
  logic [3:0]              cur_val_s;
  logic                    cur_dp_s;
  logic                    cur_vis_s;
  logic                    on_s;

  // Scan position: the first clk after reset only captures, so every frame,
  // including the first, begins with a full phase-0 dead slot.
  always_comb begin
    presc_d   = presc_q;
    phase_d   = phase_q;
    index_d   = index_q;
    start_d   = 1'b0;
    capture_s = 1'b0;
    if (start_q) begin
      capture_s = 1'b1;
    end else if (presc_q == CNT_MAX) begin
      presc_d = '0;
      phase_d = phase_q + 4'd1;
      if (phase_q == 4'd15) begin
        if (index_q == IDX_MAX) begin
          index_d   = '0;
          capture_s = 1'b1;
        end else begin
          index_d = index_q + IDX_W'(1);
        end
      end else begin
        index_d = index_q;
      end
    end else begin
      presc_d = presc_q + CNT_W'(1);
    end
  end

  // Digit visibility and the currently selected digit's attributes.
  always_comb begin
    vis_s      = '0;
    zero_run_s = 1'b1;
    cur_val_s  = 4'd0;
    cur_dp_s   = 1'b0;
    cur_vis_s  = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s & (dig_q[4*i +: 4] == 4'd0);
      vis_s[i]   = en_q[i] & ~(lz_q & zero_run_s & (i != 0));
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == index_q) begin
        cur_val_s = dig_q[4*i +: 4];
        cur_dp_s  = dp_q[i];
        cur_vis_s = vis_s[i];
      end else begin
        cur_val_s = cur_val_s;
      end
    end
  end

  // Output drive for the current (index, phase); registered one clk later.
  always_comb begin
    on_s = (phase_q != 4'd0) && (phase_q <= bright_q) && cur_vis_s;
    an_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = ~(on_s && (IDX_W'(i) == index_q));
    end
    if (on_s && (hex_q || (cur_val_s < 4'd10))) begin
      seg_d = seg_decode(cur_val_s);
    end else begin
      seg_d = 7'b1111111;
    end
    if (on_s) begin
      dpn_d = ~cur_dp_s;
    end else begin
      dpn_d = 1'b1;
    end
    fs_d = capture_s;
  end

  // State, shadow and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      phase_q  <= 4'd0;
      index_q  <= '0;
      start_q  <= 1'b1;
      dig_q    <= '0;
      dp_q     <= '0;
      en_q     <= '0;
      bright_q <= 4'd0;
      hex_q    <= 1'b0;
      lz_q     <= 1'b0;
      seg_q    <= 7'b1111111;
      dpn_q    <= 1'b1;
      an_q     <= '1;
      fs_q     <= 1'b0;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
      index_q <= index_d;
      start_q <= start_d;
      if (capture_s) begin
        dig_q    <= bus.digits;
        dp_q     <= bus.dp;
        en_q     <= bus.digit_en;
        bright_q <= bus.brightness;
        hex_q    <= bus.hex_mode;
        lz_q     <= bus.lz_blank;
      end else begin
        dig_q    <= dig_q;
      end
      seg_q <= seg_d;
      dpn_q <= dpn_d;
      an_q  <= an_d;
      fs_q  <= fs_d;
    end
  end

  assign bus.seg_n       = seg_q;
  assign bus.dp_n        = dpn_q;
  assign bus.an_n        = an_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: two instances (4 digits/div 1, 3 digits/div 3) checked
// every clk against a tick-count reference model, plus fixed vectors and sequences.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dig_v = 32'd0;
  logic [7:0]  dp_v = 8'd0;
  logic [7:0]  en_v = 8'd0;
  logic [3:0]  br_v = 4'd0;
  logic        hex_v = 1'b0;
  logic        lz_v = 1'b0;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.NUM_DIGITS(4)) ifa ();
  seg7_scan_ctrl_if #(.NUM_DIGITS(3)) ifb ();

  assign ifa.digits     = dig_v[15:0];
  assign ifa.dp         = dp_v[3:0];
  assign ifa.digit_en   = en_v[3:0];
  assign ifa.brightness = br_v;
  assign ifa.hex_mode   = hex_v;
  assign ifa.lz_blank   = lz_v;
  assign ifb.digits     = dig_v[11:0];
  assign ifb.dp         = dp_v[2:0];
  assign ifb.digit_en   = en_v[2:0];
  assign ifb.brightness = br_v;
  assign ifb.hex_mode   = hex_v;
  assign ifb.lz_blank   = lz_v;

  seg7_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  seg7_scan_ctrl #(.NUM_DIGITS(3), .CLK_DIV(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  localparam int MN [2] = '{4, 3};
  localparam int MD [2] = '{1, 3};
  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state: clks since release and the frame's captured inputs.
  int          m_e   [2] = '{0, 0};
  logic [31:0] m_dig [2] = '{32'd0, 32'd0};
  logic [7:0]  m_dp  [2] = '{8'd0, 8'd0};
  logic [7:0]  m_en  [2] = '{8'd0, 8'd0};
  logic [3:0]  m_br  [2] = '{4'd0, 4'd0};
  logic        m_hex [2] = '{1'b0, 1'b0};
  logic        m_lz  [2] = '{1'b0, 1'b0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected drive after t completed ticks, from slot arithmetic on the shadows.
  function automatic void model_out(input int k, input int t, output logic [7:0] an,
                                    output logic [6:0] seg, output logic dpn);
    int          n, p, idx, ph;
    logic [31:0] rest;
    logic [3:0]  val;
    logic        on;
    n    = MN[k];
    p    = t % (16 * n);
    idx  = p / 16;
    ph   = p % 16;
    rest = m_dig[k] >> (4 * idx);
    val  = rest[3:0];
    on   = (ph != 0) && (ph <= int'(m_br[k])) && m_en[k][idx]
           && !(m_lz[k] && idx >= 1 && rest == 32'd0);
    an  = 8'hFF;
    seg = 7'h7F;
    dpn = 1'b1;
    if (on) begin
      an  = ~(8'd1 << idx);
      dpn = ~m_dp[k][idx];
      if (m_hex[k] || val < 4'd10) seg = dec_tab[val];
    end
  endfunction

  task automatic step();
    logic [7:0] ean  [2];
    logic [6:0] eseg [2];
    logic       edpn [2];
    logic       efs  [2];
    int e, d, n, t;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_e[k] = 0; m_dig[k] = 32'd0; m_dp[k] = 8'd0; m_en[k] = 8'd0;
        m_br[k] = 4'd0; m_hex[k] = 1'b0; m_lz[k] = 1'b0;
        ean[k] = 8'hFF; eseg[k] = 7'h7F; edpn[k] = 1'b1; efs[k] = 1'b0;
      end else begin
        m_e[k]++;
        e = m_e[k]; d = MD[k]; n = MN[k];
        t = (e >= 2) ? (e - 2) / d : 0;
        model_out(k, t, ean[k], eseg[k], edpn[k]);
        efs[k] = (e == 1) || (((e - 1) % d == 0) && (((e - 1) / d) % (16 * n) == 0));
        if (efs[k]) begin
          m_dig[k] = dig_v & ((32'd1 << (4 * n)) - 32'd1);
          m_dp[k]  = dp_v & 8'((1 << n) - 1);
          m_en[k]  = en_v & 8'((1 << n) - 1);
          m_br[k]  = br_v;
          m_hex[k] = hex_v;
          m_lz[k]  = lz_v;
        end
      end
    end
    @(negedge clk);
    chk("a_an",  {28'd0, ifa.an_n},  {28'd0, ean[0][3:0]});
    chk("a_seg", {25'd0, ifa.seg_n}, {25'd0, eseg[0]});
    chk("a_dp",  {31'd0, ifa.dp_n},  {31'd0, edpn[0]});
    chk("a_fs",  {31'd0, ifa.frame_start}, {31'd0, efs[0]});
    chk("b_an",  {29'd0, ifb.an_n},  {29'd0, ean[1][2:0]});
    chk("b_seg", {25'd0, ifb.seg_n}, {25'd0, eseg[1]});
    chk("b_dp",  {31'd0, ifb.dp_n},  {31'd0, edpn[1]});
    chk("b_fs",  {31'd0, ifb.frame_start}, {31'd0, efs[1]});
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 8; i++) begin
      dig_v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    end
    dp_v  = 8'($urandom);
    en_v  = 8'($urandom) | 8'($urandom);
    br_v  = 4'($urandom);
    hex_v = 1'($urandom);
    lz_v  = 1'($urandom);
  endtask

  task automatic chk_a(input string nm, input logic [3:0] an, input logic [6:0] seg,
                       input logic dpn, input logic fs);
    chk({nm, "_an"},  {28'd0, ifa.an_n},  {28'd0, an});
    chk({nm, "_seg"}, {25'd0, ifa.seg_n}, {25'd0, seg});
    chk({nm, "_dp"},  {31'd0, ifa.dp_n},  {31'd0, dpn});
    chk({nm, "_fs"},  {31'd0, ifa.frame_start}, {31'd0, fs});
  endtask

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dp, en, br;
    logic        hex, lz;
    int          e;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dpn, fs;
  } vec_t;

  vec_t vt [$];

  initial begin
    // {digits, dp, en, bright, hex, lz, clks after release, an_n, seg_n, dp_n, frame_start}
    vt.push_back('{16'h1234, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0,  1, 4'hF, 7'h7F, 1'b1, 1'b1});
    vt.push_back('{16'h1234, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0,  2, 4'hF, 7'h7F, 1'b1, 1'b0});
    vt.push_back('{16'h1234, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0,  3, 4'hE, 7'h19, 1'b1, 1'b0});
    vt.push_back('{16'h1234, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 18, 4'hF, 7'h7F, 1'b1, 1'b0});
    vt.push_back('{16'h1234, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 19, 4'hD, 7'h30, 1'b1, 1'b0});
    vt.push_back('{16'h1234, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 40, 4'hB, 7'h24, 1'b1, 1'b0});
    vt.push_back('{16'h1234, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 65, 4'h7, 7'h79, 1'b1, 1'b1});
    vt.push_back('{16'h1234, 4'h0, 4'hF, 4'h4, 1'b0, 1'b0,  6, 4'hE, 7'h19, 1'b1, 1'b0});
    vt.push_back('{16'h1234, 4'h0, 4'hF, 4'h4, 1'b0, 1'b0,  7, 4'hF, 7'h7F, 1'b1, 1'b0});
    vt.push_back('{16'h1234, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0,  3, 4'hF, 7'h7F, 1'b1, 1'b0});
    vt.push_back('{16'h0070, 4'h0, 4'hF, 4'hF, 1'b0, 1'b1,  3, 4'hE, 7'h40, 1'b1, 1'b0});
    vt.push_back('{16'h0070, 4'h0, 4'hF, 4'hF, 1'b0, 1'b1, 19, 4'hD, 7'h78, 1'b1, 1'b0});
    vt.push_back('{16'h0070, 4'h0, 4'hF, 4'hF, 1'b0, 1'b1, 35, 4'hF, 7'h7F, 1'b1, 1'b0});
    vt.push_back('{16'h0070, 4'h0, 4'hF, 4'hF, 1'b0, 1'b1, 51, 4'hF, 7'h7F, 1'b1, 1'b0});
    vt.push_back('{16'h0000, 4'h0, 4'hF, 4'hF, 1'b0, 1'b1,  3, 4'hE, 7'h40, 1'b1, 1'b0});
    vt.push_back('{16'h0000, 4'h0, 4'hF, 4'hF, 1'b0, 1'b1, 19, 4'hF, 7'h7F, 1'b1, 1'b0});
    vt.push_back('{16'h0070, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 51, 4'h7, 7'h40, 1'b1, 1'b0});
    vt.push_back('{16'h000A, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0,  3, 4'hE, 7'h08, 1'b1, 1'b0});
    vt.push_back('{16'h000A, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0,  3, 4'hE, 7'h7F, 1'b1, 1'b0});
    vt.push_back('{16'h1234, 4'h1, 4'hF, 4'hF, 1'b0, 1'b0,  3, 4'hE, 7'h19, 1'b0, 1'b0});
    vt.push_back('{16'h1234, 4'h1, 4'hF, 4'hF, 1'b0, 1'b0, 19, 4'hD, 7'h30, 1'b1, 1'b0});
    vt.push_back('{16'h1234, 4'h0, 4'hD, 4'hF, 1'b0, 1'b0, 19, 4'hF, 7'h7F, 1'b1, 1'b0});
    vt.push_back('{16'hFEDC, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0,  3, 4'hE, 7'h46, 1'b1, 1'b0});
    vt.push_back('{16'hFEDC, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0, 19, 4'hD, 7'h21, 1'b1, 1'b0});
    vt.push_back('{16'hFEDC, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0, 35, 4'hB, 7'h06, 1'b1, 1'b0});
    vt.push_back('{16'hFEDC, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0, 51, 4'h7, 7'h0E, 1'b1, 1'b0});
    vt.push_back('{16'h9865, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0,  3, 4'hE, 7'h12, 1'b1, 1'b0});
    vt.push_back('{16'h9865, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 19, 4'hD, 7'h02, 1'b1, 1'b0});
    vt.push_back('{16'h9865, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 35, 4'hB, 7'h00, 1'b1, 1'b0});
    vt.push_back('{16'h9865, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 51, 4'h7, 7'h10, 1'b1, 1'b0});
    vt.push_back('{16'h000B, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0,  3, 4'hE, 7'h03, 1'b1, 1'b0});

    // Reset held three clks, then release: one frame_start pulse.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a("reset", 4'hF, 7'h7F, 1'b1, 1'b0);
    end
    dig_v = 32'h1234; en_v = 8'hFF; br_v = 4'hF;
    rst = 1'b0;
    step();
    chk_a("rel1", 4'hF, 7'h7F, 1'b1, 1'b1);
    step();
    chk_a("rel2", 4'hF, 7'h7F, 1'b1, 1'b0);

    // Fixed vectors, each from a fresh reset.
    foreach (vt[i]) begin
      rst = 1'b1;
      repeat (3) step();
      dig_v = {16'd0, vt[i].dig}; dp_v = {4'd0, vt[i].dp}; en_v = {4'd0, vt[i].en};
      br_v = vt[i].br; hex_v = vt[i].hex; lz_v = vt[i].lz;
      rst = 1'b0;
      repeat (vt[i].e) step();
      chk_a($sformatf("vec%0d", i), vt[i].an, vt[i].seg, vt[i].dpn, vt[i].fs);
    end

    // Inputs changed mid-frame take effect only after the next capture.
    rst = 1'b1;
    repeat (2) step();
    dig_v = 32'h1234; dp_v = 8'h0; en_v = 8'hFF; br_v = 4'hF; hex_v = 1'b0; lz_v = 1'b0;
    rst = 1'b0;
    repeat (20) step();
    dig_v = 32'h5678;
    repeat (15) step();
    chk_a("hold_s2", 4'hB, 7'h24, 1'b1, 1'b0);
    repeat (16) step();
    chk_a("hold_s3", 4'h7, 7'h79, 1'b1, 1'b0);
    repeat (14) step();
    chk_a("new_fs", 4'h7, 7'h79, 1'b1, 1'b1);
    repeat (2) step();
    chk_a("new_d0", 4'hE, 7'h00, 1'b1, 1'b0);

    // Reset mid-frame restarts at digit 0 with a fresh capture.
    repeat (10) step();
    rst = 1'b1;
    step();
    chk_a("midrst", 4'hF, 7'h7F, 1'b1, 1'b0);
    dig_v = 32'h4321;
    rst = 1'b0;
    step();
    chk_a("midrel1", 4'hF, 7'h7F, 1'b1, 1'b1);
    step();
    chk_a("midrel2", 4'hF, 7'h7F, 1'b1, 1'b0);
    step();
    chk_a("midrel3", 4'hE, 7'h79, 1'b1, 1'b0);

    // Randomized run against the model, with mid-frame input changes and resets.
    for (int r = 0; r < 40; r++) begin
      rand_inputs();
      if ($urandom_range(0, 5) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) step();
        rst = 1'b0;
      end
      for (int j = 0; j < int'($urandom_range(30, 250)); j++) begin
        step();
        if ($urandom_range(0, 31) == 0) rand_inputs();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
